// File: rtl/alu4_reg_if.sv
// Operand/select bus and registered result bus of the alu4_reg execution unit.
// The master drives operation and operands; the slave returns the registered result.
interface alu4_reg_if #(
    parameter int WIDTH = 4
);
    logic             m;
    logic             s1;
    logic             s0;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             zero;

    modport master (
        output m, s1, s0, A, B,
        input  out, carry, zero
    );

    modport slave (
        input  m, s1, s0, A, B,
        output out, carry, zero
    );
endinterface

// File: rtl/alu4_reg.sv
// Registered ALU: four unsigned arithmetic ops and four logic ops.
// Result, carry/borrow and zero flag are all captured on the same edge.
module alu4_reg #(
    parameter int WIDTH = 4
) (
    input logic       clk,
    input logic       rst,
    alu4_reg_if.slave bus
);
    logic [WIDTH-1:0] out_q, out_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic [WIDTH:0]   sum;

    always_comb begin
        out_d   = '0;
        carry_d = 1'b0;
        sum     = '0;
        case ({bus.m, bus.s1, bus.s0})
            3'b000: begin
                sum     = {1'b0, bus.A} + {1'b0, bus.B};
                out_d   = sum[WIDTH-1:0];
                carry_d = sum[WIDTH];
            end
            3'b001: begin
                out_d   = bus.A - bus.B;
                carry_d = (bus.A < bus.B);
            end
            3'b010: begin
                sum     = {1'b0, bus.A} + (WIDTH+1)'(1);
                out_d   = sum[WIDTH-1:0];
                carry_d = sum[WIDTH];
            end
            3'b011: begin
                out_d   = bus.A - WIDTH'(1);
                carry_d = (bus.A == '0);
            end
            3'b100:  out_d = bus.A & bus.B;
            3'b101:  out_d = bus.A | bus.B;
            3'b110:  out_d = bus.A ^ bus.B;
            default: out_d = ~bus.A;
        endcase
        // Flag follows the next-state result, never the live inputs.
        zero_d = (out_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            out_q   <= out_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.out   = out_q;
    assign bus.carry = carry_q;
    assign bus.zero  = zero_q;
endmodule

// File: tb/tb_alu4_reg.sv
// Bench for alu4_reg: directed literal cases plus randomized traffic,
// all checked against an integer-arithmetic reference model.
module tb_alu4_reg;
    localparam int W = 4;
    localparam int M = 1 << W;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    alu4_reg_if #(.WIDTH(W)) bus ();

    alu4_reg #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  e_out;
    int  e_c;
    int  e_z;
    bit  e_valid;

    task automatic model(input bit r, input int op, input int a,
                         input int b, output int o, output int c);
        int t;
        c = 0;
        o = 0;
        if (r) return;
        case (op)
            0: begin t = a + b; o = t % M; c = (t >= M); end
            1: begin t = a - b; o = (t + M) % M; c = (t < 0); end
            2: begin t = a + 1; o = t % M; c = (t >= M); end
            3: begin t = a - 1; o = (t + M) % M; c = (t < 0); end
            4: o = a & b;
            5: o = a | b;
            6: o = a ^ b;
            default: o = (M - 1) - a;
        endcase
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model samples the same edge as the DUT.
    always @(posedge clk) begin
        int o, c;
        model(rst, {bus.m, bus.s1, bus.s0}, bus.A, bus.B, o, c);
        e_out   = o;
        e_c     = c;
        e_z     = rst ? 1 : (o == 0);
        e_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (e_valid) begin
            chk("model_out", int'(bus.out), e_out);
            chk("model_carry", int'(bus.carry), e_c);
            chk("model_zero", int'(bus.zero), e_z);
        end
    end

    task automatic drive(input bit r, input int op, input int a, input int b);
        @(negedge clk);
        rst    = r;
        bus.m  = op[2];
        bus.s1 = op[1];
        bus.s0 = op[0];
        bus.A  = W'(a);
        bus.B  = W'(b);
    endtask

    task automatic step(input string name, input bit r, input int op,
                        input int a, input int b,
                        input int eo, input int ec, input int ez);
        drive(r, op, a, b);
        @(posedge clk);
        #1;
        chk({name, "_out"}, int'(bus.out), eo);
        chk({name, "_carry"}, int'(bus.carry), ec);
        chk({name, "_zero"}, int'(bus.zero), ez);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        e_valid  = 1'b0;
        rst      = 1'b1;
        bus.m    = 1'b0;
        bus.s1   = 1'b0;
        bus.s0   = 1'b0;
        bus.A    = 4'b1010;
        bus.B    = 4'b0111;

        @(posedge clk);
        step("reset", 1, 0, 'b1010, 'b0111, 0, 0, 1);
        step("post_reset", 0, 0, 0, 0, 0, 0, 1);

        step("add", 0, 0, 'b1010, 'b0111, 'b0001, 1, 0);
        step("sub", 0, 1, 'b1010, 'b0111, 'b0011, 0, 0);
        step("dec", 0, 3, 'b1010, 'b0111, 'b1001, 0, 0);
        step("inc", 0, 2, 'b1010, 'b0111, 'b1011, 0, 0);

        step("xor", 0, 6, 'b1010, 'b0111, 'b1101, 0, 0);
        step("not", 0, 7, 'b1010, 'b0111, 'b0101, 0, 0);
        step("or", 0, 5, 'b1010, 'b0111, 'b1111, 0, 0);
        step("and", 0, 4, 'b1010, 'b0111, 'b0010, 0, 0);

        step("inc_wrap", 0, 2, 'b1111, 0, 'b0000, 1, 1);
        step("dec_wrap", 0, 3, 'b0000, 0, 'b1111, 1, 0);
        step("sub_borrow", 0, 1, 'b0011, 'b0101, 'b1110, 1, 0);
        step("add_wrap", 0, 0, 'b1000, 'b1000, 'b0000, 1, 1);
        step("and_zero", 0, 4, 'b1010, 'b0101, 'b0000, 0, 1);

        step("add_pre", 0, 0, 'b0001, 'b0010, 'b0011, 0, 0);
        step("mid_reset", 1, 0, 'b1111, 'b1111, 0, 0, 1);
        step("after_reset", 0, 7, 'b0000, 'b0000, 'b1111, 0, 0);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 24) == 0, $urandom_range(0, 7),
                  $urandom_range(0, M - 1), $urandom_range(0, M - 1));
        end
        drive(0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
